encrypt_shift_sequencer: RTL and testbench
==========================================

Name: encrypt_shift_sequencer

Overview:
Controller that feeds the shift/scramble pipe stage from an upstream byte stream. It pre-decodes each character: alpha detection, 26-bit one-hot letter code, and selection of the per-character shift amount from a rotating 3-key schedule. It issues characters into the fixed-latency, non-stallable pipe only when it holds enough output credit. Pipe results are collected in an output FIFO that presents a valid/ready stream downstream.

Parameters:
FIFO_DEPTH, 4, output FIFO entries; minimum 3, must be at least PIPE_LAT+1.
PIPE_LAT, 2, cycles from pipe_en to pipe_en_out; fixed by the pipe stage.

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-low
start  in  1  pulse; latches cfg_k1/k2/k3/cfg_rot_freq, IDLE->RUN
stop  in  1  pulse; RUN->DRAIN
cfg_k1, cfg_k2, cfg_k3  in  8 each  key bytes; bits [2:0] give the shift amount
cfg_rot_freq  in  3  alpha characters per key; 0 = never rotate (k1 only)
din_valid  in  1  upstream byte valid
din  in  8  upstream byte (ASCII)
din_ready  out  1  upstream handshake
pipe_en  out  1  pipe issue strobe
pipe_mode  out  1  pipe mode; equals pipe_en
pipe_din  out  8  registered din
pipe_shift_en  out  1  1 when selected key[2:0] != 0
pipe_shift_amt  out  3  selected key[2:0]
pipe_extended_shift_in  out  26  alpha: one-hot letter index; otherwise {18'b0,din}
pipe_is_upper, pipe_is_lower  out  1 each  case flags
pipe_en_out  in  1  pipe result valid
pipe_data_out  in  8  pipe result
dout_valid  out  1  FIFO not empty
dout  out  8  FIFO head
dout_ready  in  1  downstream accept
busy  out  1  state != IDLE
done  out  1  one-cycle pulse on DRAIN->IDLE
err_ovf  out  1  sticky; set on pipe_en_out while FIFO full

Behaviour:
- Reset (async, rst=0): state=IDLE. All outputs 0. FIFO empty, inflight=0, key_idx=0, alpha_cnt=0. Latched config = 0.
- FSM states:
  - IDLE: din_ready=0. On start: latch config, key_idx=0, alpha_cnt=0, go to RUN. stop is ignored in IDLE.
  - RUN: start is ignored. On stop, go to DRAIN; a character accepted in the same cycle as stop is still issued.
  - DRAIN: din_ready=0. When inflight==0 and FIFO is empty: go to IDLE and pulse done for one cycle.
- Credit rule:
  - din_ready = (state==RUN) && (fifo_count + inflight < FIFO_DEPTH).
  - inflight counts issues not yet returned. It increments on pipe_en and decrements on pipe_en_out; a simultaneous increment and decrement leaves it unchanged.
- Issue:
  - On din_valid && din_ready, all pipe_* outputs are registered next cycle with pipe_en=1 for exactly one cycle. pipe_en=0 otherwise, and the other pipe_* outputs then hold their last values.
  - Issue rate is up to one character per cycle.
- Decode:
  - upper = din in 0x41..0x5A; lower = din in 0x61..0x7A.
  - One-hot = 1 << (din-0x41) for upper and 1 << (din-0x61) for lower.
  - pipe_shift_amt/pipe_shift_en always come from cfg_k[key_idx].
- Key schedule:
  - Applies only to accepted alpha characters. Non-alpha characters do not advance alpha_cnt and do not rotate.
  - If rot_freq != 0: after issuing an alpha character, alpha_cnt+1 is computed. When it equals rot_freq, alpha_cnt=0 and key_idx advances 0->1->2->0. Otherwise alpha_cnt increments.
  - The new key applies to the next character.
- Return path:
  - pipe_en_out=1 pushes pipe_data_out into the FIFO in the same cycle.
  - Pop occurs on dout_valid && dout_ready. Simultaneous push and pop is allowed at any fill level, including full.
  - A push while the FIFO is full with no pop sets err_ovf; the data is dropped and the FIFO is not corrupted. This is unreachable under the credit rule.
  - FIFO pointers wrap modulo FIFO_DEPTH.
- Latency: input accept to pipe_en is 1 cycle; to pipe_en_out is 3 cycles; to dout_valid is 4 cycles with FIFO write-through disabled (registered FIFO output).
- Output ordering: strictly in input order.
- Reset mid-operation: immediate return to reset state, FIFO contents discarded, err_ovf cleared.

Test Plan:
- k1=0x03, rot_freq=0, input 'A','Z','a' -> pipe_shift_amt=3; pipe one-hot for 'A' = 26'h1; dout = 'D'(0x44), 'C'(0x43), 'd'(0x64).
- k1=1, k2=2, k3=3, rot_freq=2, input "AAAAAAA" -> shift_amt 1,1,2,2,3,3,1; dout "BBCCDDB".
- rot_freq=1, input "A5B" -> '5' is non-alpha: extended = 26'h35, shift_amt=k2, alpha_cnt unchanged, dout '5'; 'B' uses k2.
- FIFO_DEPTH=4, dout_ready=0, 8 bytes offered -> exactly 4 accepted, then din_ready=0 and err_ovf=0. After dout_ready=1, all 8 bytes are output in order with no loss.
- stop after 3 accepted bytes, dout_ready=1 -> busy stays 1 until the 3rd dout pop, then done pulses once and state is IDLE; start while in RUN is ignored.
- rst=0 asserted while inflight=2 and FIFO holds 2 entries -> all outputs 0 asynchronously. After release, state is IDLE and dout_valid=0.

Source files
------------

// File: rtl/encrypt_shift_sequencer.sv
// encrypt_shift_sequencer
// Feeds the fixed-latency shift/scramble pipe from an upstream byte stream.
// Each accepted character is pre-decoded (case flags, one-hot letter code,
// shift amount from a rotating three-key schedule) and issued only while
// enough output credit exists. Pipe results land in a small FIFO that
// drives a valid/ready stream downstream.

module encrypt_shift_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int PIPE_LAT   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic [7:0]  cfg_k1,
    input  logic [7:0]  cfg_k2,
    input  logic [7:0]  cfg_k3,
    input  logic [2:0]  cfg_rot_freq,
    input  logic        din_valid,
    input  logic [7:0]  din,
    output logic        din_ready,
    output logic        pipe_en,
    output logic        pipe_mode,
    output logic [7:0]  pipe_din,
    output logic        pipe_shift_en,
    output logic [2:0]  pipe_shift_amt,
    output logic [25:0] pipe_extended_shift_in,
    output logic        pipe_is_upper,
    output logic        pipe_is_lower,
    input  logic        pipe_en_out,
    input  logic [7:0]  pipe_data_out,
    output logic        dout_valid,
    output logic [7:0]  dout,
    input  logic        dout_ready,
    output logic        busy,
    output logic        done,
    output logic        err_ovf
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    // The FIFO must be able to absorb every result the pipe can hold at once.
    generate
        if (FIFO_DEPTH < 3 || FIFO_DEPTH < PIPE_LAT + 1) begin : g_bad_depth
            $error("encrypt_shift_sequencer: FIFO_DEPTH too small for PIPE_LAT");
        end
    endgenerate

    logic [1:0]       state;
    logic [2:0]       key1_q;
    logic [2:0]       key2_q;
    logic [2:0]       key3_q;
    logic [2:0]       rot_q;
    logic [1:0]       key_idx;
    logic [2:0]       alpha_cnt;

    logic [CNT_W-1:0] inflight;
    logic [CNT_W-1:0] fifo_count;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [7:0]       fifo_mem [FIFO_DEPTH];

    logic             char_upper;
    logic             char_lower;
    logic             char_alpha;
    logic [4:0]       letter_idx;
    logic [25:0]      ext_code;
    logic [2:0]       sel_key;
    logic [CNT_W:0]   credit_used;
    logic             issue;
    logic             fifo_full;
    logic             push;
    logic             pop;
    logic             inflight_dec;

    // Only the low three key bits select a shift; the rest are don't-care.
    logic unused_cfg_bits;
    assign unused_cfg_bits = ^{cfg_k1[7:3], cfg_k2[7:3], cfg_k3[7:3]};

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign busy       = (state != S_IDLE);
    assign pipe_mode  = pipe_en;
    assign dout_valid = (fifo_count != '0);
    assign dout       = fifo_mem[rd_ptr];
    assign fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign pop        = dout_valid && dout_ready;
    assign push       = pipe_en_out && (!fifo_full || pop);

    // Character decode. 'A'..'Z' and 'a'..'z' share their low five bits
    // (1..26), so one subtraction gives the letter index for both cases.
    always_comb begin
        char_upper = (din >= 8'h41) && (din <= 8'h5A);
        char_lower = (din >= 8'h61) && (din <= 8'h7A);
        char_alpha = char_upper || char_lower;
        letter_idx = din[4:0] - 5'd1;
        ext_code   = char_alpha ? (26'd1 << letter_idx) : {18'b0, din};
    end

    // Shift amount for the character currently offered, from the active key.
    always_comb begin
        sel_key = key1_q;
        case (key_idx)
            2'd1:    sel_key = key2_q;
            2'd2:    sel_key = key3_q;
            default: sel_key = key1_q;
        endcase
    end

    // Credit check: results already queued plus everything still in the
    // pipe (including the issue register) must leave room in the FIFO.
    always_comb begin
        credit_used = {1'b0, fifo_count} + {1'b0, inflight};
        din_ready   = (state == S_RUN) && (credit_used < (CNT_W + 1)'(FIFO_DEPTH));
        issue       = din_valid && din_ready;
    end

    // Control FSM, configuration latch, key rotation and the done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            key1_q    <= '0;
            key2_q    <= '0;
            key3_q    <= '0;
            rot_q     <= '0;
            key_idx   <= '0;
            alpha_cnt <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        key1_q    <= cfg_k1[2:0];
                        key2_q    <= cfg_k2[2:0];
                        key3_q    <= cfg_k3[2:0];
                        rot_q     <= cfg_rot_freq;
                        key_idx   <= '0;
                        alpha_cnt <= '0;
                        state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (issue && char_alpha && (rot_q != 3'd0)) begin
                        if (alpha_cnt + 3'd1 == rot_q) begin
                            alpha_cnt <= '0;
                            key_idx   <= (key_idx == 2'd2) ? 2'd0 : key_idx + 2'd1;
                        end else begin
                            alpha_cnt <= alpha_cnt + 3'd1;
                        end
                    end
                    if (stop) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if ((inflight == '0) && (fifo_count == '0)) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Issue register: pipe inputs update only when a character is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_en                <= 1'b0;
            pipe_din               <= '0;
            pipe_shift_en          <= 1'b0;
            pipe_shift_amt         <= '0;
            pipe_extended_shift_in <= '0;
            pipe_is_upper          <= 1'b0;
            pipe_is_lower          <= 1'b0;
        end else begin
            pipe_en <= issue;
            if (issue) begin
                pipe_din               <= din;
                pipe_shift_en          <= (sel_key != 3'd0);
                pipe_shift_amt         <= sel_key;
                pipe_extended_shift_in <= ext_code;
                pipe_is_upper          <= char_upper;
                pipe_is_lower          <= char_lower;
            end
        end
    end

    // In-flight count, bumped on the same edge that raises pipe_en so the
    // credit check never sees a gap between acceptance and issue.
    assign inflight_dec = pipe_en_out && (inflight != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight <= '0;
        end else begin
            case ({issue, inflight_dec})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

    // Output FIFO with a sticky overflow flag; an overflowing push is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            err_ovf    <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= pipe_data_out;
                wr_ptr           <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            if (pipe_en_out && fifo_full && !pop) begin
                err_ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_encrypt_shift_sequencer.sv
// Testbench for encrypt_shift_sequencer: directed sessions with a behavioural
// two-stage Caesar-shift pipe attached to the pipe ports.

module tb_encrypt_shift_sequencer;

    localparam int FIFO_DEPTH = 4;
    localparam int PIPE_LAT   = 2;

    logic        clk;
    logic        rst;
    logic        start;
    logic        stop;
    logic [7:0]  cfg_k1;
    logic [7:0]  cfg_k2;
    logic [7:0]  cfg_k3;
    logic [2:0]  cfg_rot_freq;
    logic        din_valid;
    logic [7:0]  din;
    logic        din_ready;
    logic        pipe_en;
    logic        pipe_mode;
    logic [7:0]  pipe_din;
    logic        pipe_shift_en;
    logic [2:0]  pipe_shift_amt;
    logic [25:0] pipe_extended_shift_in;
    logic        pipe_is_upper;
    logic        pipe_is_lower;
    logic        pipe_en_out;
    logic [7:0]  pipe_data_out;
    logic        dout_valid;
    logic [7:0]  dout;
    logic        dout_ready;
    logic        busy;
    logic        done;
    logic        err_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    logic [2:0]  shift_q [$];
    logic        shen_q  [$];
    logic [25:0] ext_q   [$];
    logic [7:0]  dout_q  [$];

    encrypt_shift_sequencer #(
        .FIFO_DEPTH(FIFO_DEPTH),
        .PIPE_LAT  (PIPE_LAT)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .start                  (start),
        .stop                   (stop),
        .cfg_k1                 (cfg_k1),
        .cfg_k2                 (cfg_k2),
        .cfg_k3                 (cfg_k3),
        .cfg_rot_freq           (cfg_rot_freq),
        .din_valid              (din_valid),
        .din                    (din),
        .din_ready              (din_ready),
        .pipe_en                (pipe_en),
        .pipe_mode              (pipe_mode),
        .pipe_din               (pipe_din),
        .pipe_shift_en          (pipe_shift_en),
        .pipe_shift_amt         (pipe_shift_amt),
        .pipe_extended_shift_in (pipe_extended_shift_in),
        .pipe_is_upper          (pipe_is_upper),
        .pipe_is_lower          (pipe_is_lower),
        .pipe_en_out            (pipe_en_out),
        .pipe_data_out          (pipe_data_out),
        .dout_valid             (dout_valid),
        .dout                   (dout),
        .dout_ready             (dout_ready),
        .busy                   (busy),
        .done                   (done),
        .err_ovf                (err_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural pipe stage: Caesar shift within the letter's case.
    function automatic logic [7:0] scramble(input logic [7:0] c, input logic [2:0] amt,
                                            input logic sh_en, input logic up, input logic lo);
        int k;
        int v;
        k = sh_en ? int'(amt) : 0;
        v = int'(c);
        if (up) v = (v - 65 + k) % 26 + 65;
        else if (lo) v = (v - 97 + k) % 26 + 97;
        return v[7:0];
    endfunction

    logic       s1_v;
    logic       s2_v;
    logic [7:0] s1_d;
    logic [7:0] s2_d;

    // Two-cycle pipe model, reset together with the sequencer.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
            s1_d <= '0;
            s2_d <= '0;
        end else begin
            s1_v <= pipe_en;
            s1_d <= scramble(pipe_din, pipe_shift_amt, pipe_shift_en, pipe_is_upper, pipe_is_lower);
            s2_v <= s1_v;
            s2_d <= s1_d;
        end
    end

    assign pipe_en_out   = s2_v;
    assign pipe_data_out = s2_d;

    // Record issued shift settings and popped output bytes.
    always @(negedge clk) begin
        if (rst) begin
            if (pipe_en) begin
                shift_q.push_back(pipe_shift_amt);
                shen_q.push_back(pipe_shift_en);
                ext_q.push_back(pipe_extended_shift_in);
            end
            if (dout_valid && dout_ready) begin
                dout_q.push_back(dout);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Offer the bytes of s in order, advancing on each accept, for at most max_cycles.
    task automatic applyStimulus(input string s, input int max_cycles, output int n_acc);
        logic acc;
        n_acc = 0;
        for (int c = 0; c < max_cycles && n_acc < s.len(); c++) begin
            din_valid = 1'b1;
            din       = s[n_acc];
            @(negedge clk);
            acc = din_ready;
            @(posedge clk);
            #1;
            if (acc) n_acc++;
        end
        din_valid = 1'b0;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic pulseStop();
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
    endtask

    task automatic clearQueues();
        shift_q.delete();
        shen_q.delete();
        ext_q.delete();
        dout_q.delete();
    endtask

    task automatic waitPops(input string tag, input int n, input int max_cycles);
        int c;
        c = 0;
        while (dout_q.size() < n && c < max_cycles) begin
            @(posedge clk);
            #1;
            c++;
        end
        checkOutput({tag, "_pop_count"}, dout_q.size(), n);
    endtask

    task automatic waitDone(input string tag);
        logic seen;
        seen = 1'b0;
        for (int c = 0; c < 60 && !seen; c++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        checkOutput({tag, "_done_seen"}, seen, 1);
        checkOutput({tag, "_idle_at_done"}, busy, 0);
        @(negedge clk);
        checkOutput({tag, "_done_one_cycle"}, done, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic checkDout(input string tag, input string exp);
        logic [7:0] obs;
        for (int i = 0; i < exp.len(); i++) begin
            obs = (i < dout_q.size()) ? dout_q[i] : 8'hFF;
            checkOutput($sformatf("%s_dout%0d", tag, i), obs, exp[i]);
        end
    endtask

    task automatic checkShift(input string tag, input int idx, input logic [2:0] exp);
        logic [2:0] obs;
        obs = (idx < shift_q.size()) ? shift_q[idx] : 3'bxxx;
        checkOutput($sformatf("%s_shift%0d", tag, idx), obs, exp);
    endtask

    initial begin
        int   n_acc;
        int   pops;
        logic early_idle;
        logic seen;
        string exp2;
        logic [2:0] amt2 [7];

        rst = 1'b0; start = 1'b0; stop = 1'b0;
        cfg_k1 = '0; cfg_k2 = '0; cfg_k3 = '0; cfg_rot_freq = '0;
        din_valid = 1'b0; din = '0; dout_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rst_din_ready", din_ready, 0);
        checkOutput("rst_pipe_en", pipe_en, 0);
        checkOutput("rst_pipe_mode", pipe_mode, 0);
        checkOutput("rst_pipe_din", pipe_din, 0);
        checkOutput("rst_pipe_ext", pipe_extended_shift_in, 0);
        checkOutput("rst_dout_valid", dout_valid, 0);
        checkOutput("rst_dout", dout, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_err_ovf", err_ovf, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Session 1: k1=3, no rotation, "AZa", with latency walk on 'A'
        $display("[TB] session 1: fixed key 3");
        clearQueues();
        cfg_k1 = 8'h03; cfg_k2 = 8'h00; cfg_k3 = 8'h00; cfg_rot_freq = 3'd0;
        dout_ready = 1'b1;
        pulseStart();
        din_valid = 1'b1; din = 8'h41;
        @(negedge clk);
        checkOutput("t1_busy", busy, 1);
        checkOutput("t1_din_ready", din_ready, 1);
        @(posedge clk); #1;
        din_valid = 1'b0;
        @(negedge clk);
        checkOutput("t1_pipe_en", pipe_en, 1);
        checkOutput("t1_pipe_mode", pipe_mode, 1);
        checkOutput("t1_pipe_din", pipe_din, 8'h41);
        checkOutput("t1_shift_amt", pipe_shift_amt, 3);
        checkOutput("t1_shift_en", pipe_shift_en, 1);
        checkOutput("t1_onehot_A", pipe_extended_shift_in, 26'h1);
        checkOutput("t1_is_upper", pipe_is_upper, 1);
        checkOutput("t1_is_lower", pipe_is_lower, 0);
        @(negedge clk);
        checkOutput("t1_pipe_en_low", pipe_en, 0);
        checkOutput("t1_pipe_din_hold", pipe_din, 8'h41);
        @(negedge clk);
        checkOutput("t1_dout_valid_c3", dout_valid, 0);
        @(negedge clk);
        checkOutput("t1_dout_valid_c4", dout_valid, 1);
        checkOutput("t1_dout_c4", dout, 8'h44);
        @(posedge clk); #1;
        applyStimulus("Za", 20, n_acc);
        checkOutput("t1_accepted", n_acc, 2);
        waitPops("t1", 3, 40);
        checkDout("t1", "DCd");
        for (int i = 0; i < 3; i++) checkShift("t1", i, 3'd3);
        checkOutput("t1_onehot_Z", (ext_q.size() > 1) ? ext_q[1] : 26'h0, 26'h2000000);
        checkOutput("t1_onehot_a", (ext_q.size() > 2) ? ext_q[2] : 26'h0, 26'h1);
        pulseStop();
        waitDone("t1");

        // Session 2: keys 1/2/3 rotating every two letters
        $display("[TB] session 2: key rotation every 2");
        clearQueues();
        cfg_k1 = 8'h01; cfg_k2 = 8'h02; cfg_k3 = 8'h03; cfg_rot_freq = 3'd2;
        pulseStart();
        applyStimulus("AAAAAAA", 40, n_acc);
        checkOutput("t2_accepted", n_acc, 7);
        waitPops("t2", 7, 40);
        amt2 = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd1};
        for (int i = 0; i < 7; i++) checkShift("t2", i, amt2[i]);
        exp2 = "BBCCDDB";
        checkDout("t2", exp2);
        pulseStop();
        waitDone("t2");

        // Session 3: non-alpha character neither rotates nor counts
        $display("[TB] session 3: non-alpha in stream");
        clearQueues();
        cfg_rot_freq = 3'd1;
        pulseStart();
        applyStimulus("A5B", 20, n_acc);
        checkOutput("t3_accepted", n_acc, 3);
        waitPops("t3", 3, 40);
        checkShift("t3", 0, 3'd1);
        checkShift("t3", 1, 3'd2);
        checkShift("t3", 2, 3'd2);
        checkOutput("t3_ext_digit", (ext_q.size() > 1) ? ext_q[1] : 26'h0, 26'h35);
        checkDout("t3", "B5D");
        pulseStop();
        waitDone("t3");

        // Session 4: back-pressure limits acceptance to FIFO_DEPTH
        $display("[TB] session 4: credit limit");
        clearQueues();
        cfg_k1 = 8'h01; cfg_rot_freq = 3'd0;
        dout_ready = 1'b0;
        pulseStart();
        applyStimulus("ABCDEFGH", 12, n_acc);
        checkOutput("t4_accepted_blocked", n_acc, 4);
        @(negedge clk);
        checkOutput("t4_din_ready_low", din_ready, 0);
        checkOutput("t4_err_ovf", err_ovf, 0);
        checkOutput("t4_dout_valid", dout_valid, 1);
        checkOutput("t4_dout_head", dout, 8'h42);
        @(posedge clk); #1;
        dout_ready = 1'b1;
        applyStimulus("EFGH", 40, n_acc);
        checkOutput("t4_accepted_rest", n_acc, 4);
        waitPops("t4", 8, 60);
        checkDout("t4", "BCDEFGHI");
        checkOutput("t4_err_ovf_end", err_ovf, 0);
        pulseStop();
        waitDone("t4");

        // Session 5: start ignored in RUN, stop with a same-cycle accept
        $display("[TB] session 5: stop and drain");
        clearQueues();
        cfg_k1 = 8'h00; cfg_rot_freq = 3'd0;
        pulseStart();
        applyStimulus("x", 10, n_acc);
        cfg_k1 = 8'h05;
        pulseStart();
        applyStimulus("y", 10, n_acc);
        din_valid = 1'b1; din = 8'h7A; stop = 1'b1;
        @(negedge clk);
        checkOutput("t5_ready_at_stop", din_ready, 1);
        @(posedge clk); #1;
        din_valid = 1'b0; stop = 1'b0;
        @(negedge clk);
        checkOutput("t5_drain_busy", busy, 1);
        checkOutput("t5_drain_not_ready", din_ready, 0);
        early_idle = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 60 && !seen; c++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            else if (!busy) early_idle = 1'b1;
        end
        checkOutput("t5_done_seen", seen, 1);
        checkOutput("t5_busy_held", early_idle, 0);
        checkOutput("t5_idle_at_done", busy, 0);
        @(negedge clk);
        checkOutput("t5_done_one_cycle", done, 0);
        @(posedge clk); #1;
        pops = dout_q.size();
        checkOutput("t5_pops_at_done", pops, 3);
        for (int i = 0; i < 3; i++) checkShift("t5", i, 3'd0);
        checkOutput("t5_shift_en", (shen_q.size() > 2) ? shen_q[2] : 1'b1, 0);
        checkDout("t5", "xyz");

        // Session 6: asynchronous reset with work in flight
        $display("[TB] session 6: reset mid-operation");
        clearQueues();
        cfg_k1 = 8'h01;
        dout_ready = 1'b0;
        pulseStart();
        applyStimulus("ABCD", 10, n_acc);
        checkOutput("t6_accepted", n_acc, 4);
        @(posedge clk); #1;
        checkOutput("t6_pre_dout_valid", dout_valid, 1);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("t6_rst_busy", busy, 0);
        checkOutput("t6_rst_dout_valid", dout_valid, 0);
        checkOutput("t6_rst_dout", dout, 0);
        checkOutput("t6_rst_pipe_din", pipe_din, 0);
        checkOutput("t6_rst_shift_amt", pipe_shift_amt, 0);
        checkOutput("t6_rst_is_upper", pipe_is_upper, 0);
        checkOutput("t6_rst_ext", pipe_extended_shift_in, 0);
        checkOutput("t6_rst_err_ovf", err_ovf, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("t6_post_busy", busy, 0);
        checkOutput("t6_post_dout_valid", dout_valid, 0);
        checkOutput("t6_post_din_ready", din_ready, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
